// File: rtl/dmem_pkg.sv
// Shared definitions for the line-granular data memory: line geometry and FSM states.
package dmem_pkg;

    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_line_array.sv
// Single-port 256-bit line store: synchronous write, read data registered on re.
module dmem_line_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] index,
    input  logic [LINE_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/dmem_line.sv
// Fixed-latency line memory behind the data cache: one line read/write per request,
// one-cycle ack, read data held until the next read completes.
module dmem_line
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned LINE_ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ack_q;
    logic                   rd_valid_q;

    logic [LINE_ADDR_W-1:0] idx_q;
    logic                   wr_q;
    logic [LINE_W-1:0]      data_q;
    logic                   latch;

    logic                   commit;
    logic                   commit_wr;
    logic [LINE_ADDR_W-1:0] commit_idx;
    logic [LINE_W-1:0]      commit_data;
    logic                   arr_we;
    logic                   arr_re;
    logic [LINE_W-1:0]      arr_rdata;

    logic [LINE_ADDR_W-1:0] req_idx;
    logic                   unused_addr;

    assign req_idx     = addr_i[LINE_ADDR_W+OFFSET_W-1:OFFSET_W];
    assign unused_addr = ^{addr_i[31:LINE_ADDR_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        latch       = 1'b0;
        commit      = 1'b0;
        commit_wr   = wr_q;
        commit_idx  = idx_q;
        commit_data = data_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    latch = 1'b1;
                    cnt_d = CNT_W'(LATENCY - 1);
                    // With single-cycle latency the commit edge is the acceptance edge,
                    // so the array must see the live request rather than the latches.
                    if (LATENCY == 1) begin
                        state_d     = ACK;
                        commit      = 1'b1;
                        commit_wr   = write_i;
                        commit_idx  = req_idx;
                        commit_data = data_i;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    commit  = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset gates the array strobes so an aborted write never lands.
    assign arr_we = rst_i & commit & commit_wr;
    assign arr_re = rst_i & commit & ~commit_wr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == ACK);
            if (arr_re) begin
                rd_valid_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (latch) begin
            idx_q  <= req_idx;
            wr_q   <= write_i;
            data_q <= data_i;
        end
    end

    dmem_line_array #(
        .ADDR_W (LINE_ADDR_W)
    ) u_array (
        .clk   (clk_i),
        .index (commit_idx),
        .wdata (commit_data),
        .we    (arr_we),
        .re    (arr_re),
        .rdata (arr_rdata)
    );

    assign ack_o  = ack_q;
    // The array register only changes on a read commit; the valid flag provides the reset clear.
    assign data_o = rd_valid_q ? arr_rdata : '0;

endmodule
